mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port req_valid, input, 1 bit: CPU presents a load/store request.
REQ-004 SHALL have port req_ready, output, 1 bit: unit can accept a request this cycle.
REQ-005 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port req_base, input, 32 bits: base register value.
REQ-007 SHALL have port req_offset, input, 32 bits signed: sign-extended immediate.
REQ-008 SHALL have port req_wdata, input, 32 bits: store data.
REQ-009 SHALL have port resp_valid, output, 1 bit: one-cycle pulse, load data valid.
REQ-010 SHALL have port resp_data, output, 32 bits signed: load result.
REQ-011 SHALL have port fault, output, 1 bit: one-cycle pulse, out-of-range access.
REQ-012 SHALL have port mem_addr, output, 32 bits: word address to data memory.
REQ-013 SHALL have port mem_wrData, output, 32 bits: data memory write data.
REQ-014 SHALL have ports mem_wrMem and mem_rdMem, outputs, 1 bit each: data memory strobes.
REQ-015 SHALL have port mem_rdData, input, 32 bits: registered data memory read data, valid one cycle after mem_rdMem.
REQ-016 SHALL have ports ld_count and st_count, outputs, 16 bits each: completed-access counters.

Function
REQ-017 SHALL compute the effective word address as req_base + req_offset, modulo 2^32, and latch it together with req_we and req_wdata on acceptance.
REQ-018 SHALL use FSM states IDLE, WR, RD_ISSUE, RD_CAPT and RESP.
REQ-019 SHALL drive req_ready=1 only in IDLE; acceptance = req_valid & req_ready at a rising edge.
REQ-020 SHALL move IDLE->WR on an accepted store and IDLE->RD_ISSUE on an accepted load.
REQ-021 SHALL assert mem_wrMem for exactly the one WR cycle, then move WR->IDLE; a store occupies 2 cycles.
REQ-022 SHALL assert mem_rdMem for the one RD_ISSUE cycle, then move to RD_CAPT.
REQ-023 SHALL register mem_rdData into resp_data in RD_CAPT, then move to RESP.
REQ-024 SHALL drive resp_valid=1 for the RESP cycle only, then move to IDLE; accept-edge to resp_valid is 3 cycles.
REQ-025 SHALL hold resp_data until the next load completes.
REQ-026 SHALL keep mem_wrMem and mem_rdMem mutually exclusive and never both high.
REQ-027 SHALL ignore req_valid while req_ready=0, with no queuing.
REQ-028 SHALL increment ld_count on each resp_valid and st_count on each WR cycle, saturating at 0xFFFF.

Reset
REQ-029 SHALL, while rst=1 in any state, go to IDLE and force req_ready=0, resp_valid=0, fault=0, mem_wrMem=0, mem_rdMem=0, resp_data=0, mem_addr=0, mem_wrData=0, ld_count=0 and st_count=0.
REQ-030 SHALL abort an in-flight access on rst with no strobe and no response, and set req_ready=1 in the first cycle after rst falls.

Configuration
REQ-031 SHALL, with BOUNDS_CHECK_EN defined, treat an effective address >= 1024 (unsigned) as a fault.
REQ-032 SHALL, with BOUNDS_CHECK_EN defined, handle a faulting store by going to WR with no mem_wrMem, pulsing fault in that cycle and leaving st_count unchanged.
REQ-033 SHALL, with BOUNDS_CHECK_EN defined, handle a faulting load by skipping mem_rdMem and returning resp_valid=1, resp_data=0 and fault=1 in the same cycle, at the normal 3-cycle latency.
REQ-034 SHALL, without BOUNDS_CHECK_EN, tie fault to 0 and let the memory index wrap on addr[9:0].

Structure
REQ-035 SHALL define the FSM state encodings, MEM_DEPTH=1024 and IDX_W=10 in the shared package mem_access_pkg.
REQ-036 SHALL place the adder and bounds compare in one combinational sub-module, addr_gen.

Verification
REQ-037 SHALL cover: memory reset contents, load base=0 offset=2 -> resp_valid 3 cycles after accept with resp_data=89, ld_count=1.
REQ-038 SHALL cover: store base=4 offset=1 wdata=100, then load base=6 offset=-1 -> resp_data=100, st_count=1.
REQ-039 SHALL cover: req_valid held high for 6 cycles starting with a load -> exactly one accepted at the first edge and the next accepted after RESP; req_ready low in between.
REQ-040 SHALL cover, with BOUNDS_CHECK_EN: load base=1020 offset=10 -> fault=1, resp_data=0, no mem_rdMem; without it, mem index 6 is read -> resp_data=12.
REQ-041 SHALL cover: rst asserted during RD_CAPT -> no resp_valid, counters 0, req_ready=1 in the cycle after rst falls.
REQ-042 SHALL cover: 65,540 stores -> st_count saturates at 65535.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store unit: FSM state encodings and data-memory geometry.
package mem_access_pkg;

  localparam int MEM_DEPTH = 1024;
  localparam int IDX_W     = 10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_ISSUE = 3'd2,
    RD_CAPT  = 3'd3,
    RESP     = 3'd4
  } state_t;

endpackage

// File: rtl/addr_gen.sv
// Effective-address adder plus range compare against MEM_DEPTH.
// The range compare exists only when BOUNDS_CHECK_EN is defined; otherwise nothing is ever out of range.
module addr_gen
  import mem_access_pkg::*;
(
  input  logic [31:0]        base,
  input  logic signed [31:0] offset,
  output logic [31:0]        eff_addr,
  output logic               out_of_range
);

  // Two's-complement add: a negative offset wraps modulo 2^32.
  assign eff_addr = base + $unsigned(offset);

`ifdef BOUNDS_CHECK_EN
  assign out_of_range = (eff_addr >= 32'(MEM_DEPTH));
`else
  assign out_of_range = 1'b0;
`endif

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit driving a registered-read data memory, with saturating
// completion counters. Optional bounds checking is selected by BOUNDS_CHECK_EN (in addr_gen).
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter logic [15:0] CNT_MAX = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [31:0]        req_base,
  input  logic signed [31:0] req_offset,
  input  logic [31:0]        req_wdata,
  output logic               resp_valid,
  output logic signed [31:0] resp_data,
  output logic               fault,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_wrData,
  output logic               mem_wrMem,
  output logic               mem_rdMem,
  input  logic [31:0]        mem_rdData,
  output logic [15:0]        ld_count,
  output logic [15:0]        st_count
);

  state_t      state;
  logic [31:0] eff_addr;
  logic        oob;
  logic        flt_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v >= CNT_MAX) ? v : v + 16'd1;
  endfunction

  addr_gen u_addr_gen (
    .base         (req_base),
    .offset       (req_offset),
    .eff_addr     (eff_addr),
    .out_of_range (oob)
  );

  // Gated by rst so the unit is ready in the very first cycle after reset is released.
  assign req_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      flt_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      fault      <= 1'b0;
      mem_addr   <= '0;
      mem_wrData <= '0;
      mem_wrMem  <= 1'b0;
      mem_rdMem  <= 1'b0;
      ld_count   <= '0;
      st_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_addr   <= eff_addr;
            mem_wrData <= req_wdata;
            flt_q      <= oob;
            if (req_we) begin
              state     <= WR;
              mem_wrMem <= !oob;
              fault     <= oob;
            end else begin
              state     <= RD_ISSUE;
              mem_rdMem <= !oob;
            end
          end
        end
        WR: begin
          mem_wrMem <= 1'b0;
          fault     <= 1'b0;
          if (!flt_q) st_count <= sat_inc(st_count);
          state     <= IDLE;
        end
        RD_ISSUE: begin
          mem_rdMem <= 1'b0;
          state     <= RD_CAPT;
        end
        RD_CAPT: begin
          // A faulting load never touched memory, so return zero instead of stale read data.
          resp_data  <= flt_q ? '0 : $signed(mem_rdData);
          resp_valid <= 1'b1;
          fault      <= flt_q;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          fault      <= 1'b0;
          ld_count   <= sat_inc(ld_count);
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: registered-read memory, transaction-level reference model, directed
// and random loads/stores. Follows BOUNDS_CHECK_EN the same way the design does.
module tb_mem_access_unit;

  localparam int SAT = 40;
`ifdef BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic               req_we = 1'b0;
  logic [31:0]        req_base = '0;
  logic signed [31:0] req_offset = '0;
  logic [31:0]        req_wdata = '0;
  logic               resp_valid;
  logic signed [31:0] resp_data;
  logic               fault;
  logic [31:0]        mem_addr;
  logic [31:0]        mem_wrData;
  logic               mem_wrMem;
  logic               mem_rdMem;
  logic [31:0]        mem_rdData;
  logic [15:0]        ld_count;
  logic [15:0]        st_count;

  int total = 0;
  int bad = 0;
  int rd_pulses = 0, wr_pulses = 0, resp_pulses = 0, both_hi = 0;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  int exp_ld, exp_st;

  mem_access_unit #(.CNT_MAX(16'(SAT))) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_base   (req_base),
    .req_offset (req_offset),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .fault      (fault),
    .mem_addr   (mem_addr),
    .mem_wrData (mem_wrData),
    .mem_wrMem  (mem_wrMem),
    .mem_rdMem  (mem_rdMem),
    .mem_rdData (mem_rdData),
    .ld_count   (ld_count),
    .st_count   (st_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return (i == 2) ? 32'd89 : 32'(i * 2);
  endfunction

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  function automatic bit is_oob(input logic [31:0] a);
    return BOUNDS && (a >= 32'd1024);
  endfunction

  // Data memory: registered read one cycle after mem_rdMem, contents restored on reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
      mem_rdData <= '0;
    end else begin
      if (mem_wrMem) mem[mem_addr[9:0]] <= mem_wrData;
      if (mem_rdMem) mem_rdData <= mem[mem_addr[9:0]];
    end
  end

  always @(posedge clk) begin
    if (mem_rdMem) rd_pulses++;
    if (mem_wrMem) wr_pulses++;
    if (resp_valid) resp_pulses++;
    if (mem_rdMem && mem_wrMem) both_hi++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    exp_ld = 0;
    exp_st = 0;
  endtask

  task automatic do_load(input logic [31:0] b, input logic signed [31:0] o, input string tag);
    logic [31:0] a, expd;
    bit f;
    int n, rd0;
    a = b + o;
    f = is_oob(a);
    expd = f ? 32'd0 : ref_mem[a[9:0]];
    @(negedge clk);
    chk({tag, "_ready"}, req_ready, 1);
    req_valid = 1; req_we = 0; req_base = b; req_offset = o; req_wdata = $urandom;
    rd0 = rd_pulses;
    @(posedge clk);
    #1 req_valid = 0;
    chk({tag, "_addr"}, mem_addr, a);
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (resp_valid) break;
    end
    chk({tag, "_latency"}, n, 3);
    chk({tag, "_data"}, resp_data, expd);
    chk({tag, "_fault"}, fault, f);
    chk({tag, "_rdmem"}, rd_pulses - rd0, f ? 0 : 1);
    exp_ld = sat(exp_ld + 1);
    @(negedge clk);
    chk({tag, "_vld_drop"}, resp_valid, 0);
    chk({tag, "_ldcnt"}, ld_count, exp_ld);
    chk({tag, "_hold"}, resp_data, expd);
  endtask

  task automatic do_store(input logic [31:0] b, input logic signed [31:0] o,
                          input logic [31:0] d, input string tag);
    logic [31:0] a;
    bit f;
    int wr0;
    a = b + o;
    f = is_oob(a);
    @(negedge clk);
    chk({tag, "_ready"}, req_ready, 1);
    req_valid = 1; req_we = 1; req_base = b; req_offset = o; req_wdata = d;
    wr0 = wr_pulses;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk({tag, "_wrmem"}, mem_wrMem, !f);
    chk({tag, "_fault"}, fault, f);
    chk({tag, "_busy"}, req_ready, 0);
    chk({tag, "_wdata"}, mem_wrData, d);
    @(negedge clk);
    chk({tag, "_pulses"}, wr_pulses - wr0, f ? 0 : 1);
    if (!f) begin
      ref_mem[a[9:0]] = d;
      exp_st = sat(exp_st + 1);
    end
    chk({tag, "_stcnt"}, st_count, exp_st);
    chk({tag, "_fault_clr"}, fault, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, n, resp0;
    model_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_fault", fault, 0);
    chk("rst_wrmem", mem_wrMem, 0);
    chk("rst_rdmem", mem_rdMem, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wrdata", mem_wrData, 0);
    chk("rst_ldcnt", ld_count, 0);
    chk("rst_stcnt", st_count, 0);
    rst = 0;
    #1 chk("rst_release_ready", req_ready, 1);

    do_load(32'd0, 32'sd2, "ld_init");
    chk("ld_init_89", resp_data, 89);
    chk("ld_init_cnt1", ld_count, 1);

    do_store(32'd4, 32'sd1, 32'd100, "st_5");
    do_load(32'd6, -32'sd1, "ld_5");
    chk("ld_5_100", resp_data, 100);
    chk("st_5_cnt1", st_count, 1);

    // req_valid held for 6 cycles: a load busies the unit for 4 cycles.
    @(negedge clk);
    req_valid = 1; req_we = 0; req_base = 32'd0; req_offset = 32'sd6;
    resp0 = resp_pulses;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      chk("b2b_ready", req_ready, (c % 4 == 0) ? 1 : 0);
      if (req_ready) acc++;
      @(negedge clk);
    end
    req_valid = 0;
    chk("b2b_accepts", acc, 2);
    n = 0;
    while (n < 10 && !resp_valid) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_second_resp", resp_valid, 1);
    chk("b2b_data", resp_data, ref_mem[6]);
    @(negedge clk);
    exp_ld = sat(exp_ld + 2);
    chk("b2b_resp_count", resp_pulses - resp0, 2);
    chk("b2b_ldcnt", ld_count, exp_ld);

    do_load(32'd1020, 32'sd10, "ld_oob");
    chk("ld_oob_data", resp_data, BOUNDS ? 0 : 12);
    do_store(32'd1023, 32'sd1, 32'hDEAD_BEEF, "st_oob");

    for (int k = 0; k < 24; k++) begin
      logic [31:0] b;
      logic signed [31:0] o;
      b = $urandom_range(0, 1100);
      o = $urandom_range(0, 200) - 100;
      if ($urandom_range(0, 1) == 1) do_store(b, o, $urandom, "rnd_st");
      else do_load(b, o, "rnd_ld");
    end

    // Reset while the load sits in RD_CAPT: the access must vanish without a response.
    @(negedge clk);
    req_valid = 1; req_we = 0; req_base = 32'd0; req_offset = 32'sd2;
    resp0 = resp_pulses;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_ready_in_rst", req_ready, 0);
    chk("abort_ldcnt", ld_count, 0);
    chk("abort_stcnt", st_count, 0);
    chk("abort_rdmem", mem_rdMem, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
    #1 chk("abort_ready_after", req_ready, 1);
    repeat (4) @(negedge clk);
    chk("abort_no_resp", resp_pulses - resp0, 0);
    chk("abort_ldcnt_after", ld_count, 0);
    do_load(32'd0, 32'sd2, "ld_after_rst");

    for (int k = 0; k < SAT + 5; k++)
      do_store(32'($urandom_range(0, 500)), 32'sd3, $urandom, "sat_st");
    chk("sat_stcnt", st_count, SAT);

    chk("strobe_exclusive", both_hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
